// File: rtl/matmul_chain_seq.sv
// Two-layer chained matrix-vector engine: layer 1 accumulates scalar-weighted activation
// vectors into a requantised temp buffer, layer 2 re-weights the buffered rows into the result.
module matmul_chain_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int MAC_NUM      = 8,
  parameter int K1           = 8,
  parameter int DEPTH        = 8
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [4:0]                     shift_i,
  input  logic                           l1_valid_i,
  output logic                           l1_ready_o,
  input  logic [MAC_NUM*DATA_WIDTH-1:0]  l1_din_i,
  input  logic [WEIGHT_WIDTH-1:0]        l1_win_i,
  input  logic                           l2_valid_i,
  output logic                           l2_ready_o,
  input  logic [WEIGHT_WIDTH-1:0]        l2_win_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           sat_o,
  output logic [MAC_NUM*ACC_WIDTH-1:0]   matmul_o
);

  typedef enum logic [2:0] {IDLE, L1_ACC, L1_WB, L2_ACC, DONE} state_t;

  // Counters keep at least one bit so K1 == 1 and DEPTH == 1 still elaborate.
  localparam int BEAT_W = (K1 > 1) ? $clog2(K1) : 1;
  localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(K1 - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DEPTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] Q_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ~Q_MAX;

  state_t state, state_nxt;
  logic [BEAT_W-1:0] beat;
  logic [ROW_W-1:0]  row;
  logic [4:0]        shift_q;
  logic              sat_q;
  logic [MAC_NUM*ACC_WIDTH-1:0] matmul_q;

  logic signed [ACC_WIDTH-1:0]  acc     [MAC_NUM];
  logic signed [ACC_WIDTH-1:0]  acc_nxt [MAC_NUM];
  logic signed [ACC_WIDTH-1:0]  op_x    [MAC_NUM];
  logic signed [ACC_WIDTH-1:0]  shifted [MAC_NUM];
  logic signed [DATA_WIDTH-1:0] q_lane  [MAC_NUM];
  logic signed [DATA_WIDTH-1:0] temp    [DEPTH][MAC_NUM];
  logic signed [ACC_WIDTH-1:0]  op_w;
  logic [MAC_NUM-1:0]           clamp;

  logic l1_fire, l2_fire, abort_hit;

  assign l1_ready_o = (state == L1_ACC);
  assign l2_ready_o = (state == L2_ACC);
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);
  assign sat_o      = sat_q;
  assign matmul_o   = matmul_q;

  assign l1_fire   = l1_ready_o & l1_valid_i;
  assign l2_fire   = l2_ready_o & l2_valid_i;
  assign abort_hit = abort_i & (state != IDLE);

  // One multiplier per lane, shared by both layers; operands sign-extend to the accumulator width.
  assign op_w = (state == L2_ACC) ? ACC_WIDTH'($signed(l2_win_i)) : ACC_WIDTH'($signed(l1_win_i));

  // NOTE: every combinational output is assigned on every path, so no latch is inferred.
  always_comb begin
    clamp = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      if (state == L2_ACC) op_x[i] = ACC_WIDTH'(temp[row][i]);
      else                 op_x[i] = ACC_WIDTH'($signed(l1_din_i[i*DATA_WIDTH +: DATA_WIDTH]));
      acc_nxt[i] = acc[i] + op_x[i] * op_w;
      shifted[i] = acc[i] >>> shift_q;
      if (shifted[i] > Q_MAX) begin
        q_lane[i] = Q_MAX[DATA_WIDTH-1:0];
        clamp[i]  = 1'b1;
      end else if (shifted[i] < Q_MIN) begin
        q_lane[i] = Q_MIN[DATA_WIDTH-1:0];
        clamp[i]  = 1'b1;
      end else begin
        q_lane[i] = shifted[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = L1_ACC;
      L1_ACC:  if (l1_fire && beat == BEAT_LAST) state_nxt = L1_WB;
      L1_WB:   state_nxt = (row == ROW_LAST) ? L2_ACC : L1_ACC;
      L2_ACC:  if (l2_fire && row == ROW_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beat     <= '0;
      row      <= '0;
      shift_q  <= '0;
      sat_q    <= 1'b0;
      matmul_q <= '0;
      for (int i = 0; i < MAC_NUM; i++) acc[i] <= '0;
    end else if (!abort_hit) begin
      case (state)
        IDLE: if (start_i) begin
          beat    <= '0;
          row     <= '0;
          sat_q   <= 1'b0;
          shift_q <= shift_i;
          for (int i = 0; i < MAC_NUM; i++) acc[i] <= '0;
        end
        L1_ACC: if (l1_fire) begin
          beat <= beat + 1'b1;
          for (int i = 0; i < MAC_NUM; i++) acc[i] <= acc_nxt[i];
        end
        L1_WB: begin
          beat <= '0;
          row  <= (row == ROW_LAST) ? '0 : row + 1'b1;
          if (|clamp) sat_q <= 1'b1;
          for (int i = 0; i < MAC_NUM; i++) acc[i] <= '0;
        end
        L2_ACC: if (l2_fire) begin
          row <= row + 1'b1;
          for (int i = 0; i < MAC_NUM; i++) acc[i] <= acc_nxt[i];
          // The final beat's sum goes straight into the result, landing on the edge into DONE.
          if (row == ROW_LAST)
            for (int i = 0; i < MAC_NUM; i++) matmul_q[i*ACC_WIDTH +: ACC_WIDTH] <= acc_nxt[i];
        end
        default: ;
      endcase
    end
  end

  // NOTE: temp is deliberately not reset; layer 1 writes every row before layer 2 reads it.
  always_ff @(posedge clk_i) begin
    if (state == L1_WB && !abort_hit)
      for (int i = 0; i < MAC_NUM; i++) temp[row][i] <= q_lane[i];
  end

endmodule

// File: tb/tb_matmul_chain_seq.sv
// Self-checking bench for matmul_chain_seq: directed jobs plus randomized jobs, all checked
// against a plain-arithmetic model of the two chained layers.
module tb_matmul_chain_seq;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 32;
  localparam int MN = 8;
  localparam int K1 = 8;
  localparam int DEPTH = 8;
  localparam int VW = MN * AW;
  localparam int BASE_LAT = DEPTH * (K1 + 1) + DEPTH + 1;

  logic clk_i, rstn_i, start_i, abort_i;
  logic [4:0] shift_i;
  logic l1_valid_i, l1_ready_o, l2_valid_i, l2_ready_o;
  logic [MN*DW-1:0] l1_din_i;
  logic [WW-1:0] l1_win_i, l2_win_i;
  logic busy_o, done_o, sat_o;
  logic [VW-1:0] matmul_o;

  matmul_chain_seq #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .MAC_NUM(MN), .K1(K1), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i), .shift_i(shift_i),
    .l1_valid_i(l1_valid_i), .l1_ready_o(l1_ready_o), .l1_din_i(l1_din_i), .l1_win_i(l1_win_i),
    .l2_valid_i(l2_valid_i), .l2_ready_o(l2_ready_o), .l2_win_i(l2_win_i),
    .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .matmul_o(matmul_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int bubbles = 0;
  bit done_expected = 1'b0;
  logic [VW-1:0] exp_vec = '0;
  logic [VW-1:0] pend_vec = '0;
  bit pend_sat = 1'b0;

  byte job_din [DEPTH][K1][MN];
  byte job_w1  [DEPTH][K1];
  byte job_w2  [DEPTH];
  int  job_shift;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] vec_all(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < MN; i++) r[i*AW +: AW] = v[AW-1:0];
    return r;
  endfunction

  // Reference: per lane, each row is sum(din*w1) >>> shift clamped to 8 bits, then weighted by w2.
  task automatic compute_model();
    pend_sat = 1'b0;
    for (int i = 0; i < MN; i++) begin
      int res = 0;
      for (int r = 0; r < DEPTH; r++) begin
        int s = 0;
        for (int k = 0; k < K1; k++) s += int'(job_din[r][k][i]) * int'(job_w1[r][k]);
        s = s >>> job_shift;
        if (s > 127) begin s = 127; pend_sat = 1'b1; end
        else if (s < -128) begin s = -128; pend_sat = 1'b1; end
        res += s * int'(job_w2[r]);
      end
      pend_vec[i*AW +: AW] = res;
    end
  endtask

  task automatic fill_const(input int d, input int w1, input int w2, input int sh);
    for (int r = 0; r < DEPTH; r++) begin
      job_w2[r] = byte'(w2);
      for (int k = 0; k < K1; k++) begin
        job_w1[r][k] = byte'(w1);
        for (int i = 0; i < MN; i++) job_din[r][k][i] = byte'(d);
      end
    end
    job_shift = sh;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < DEPTH; r++) begin
      job_w2[r] = byte'($urandom_range(0, 255));
      for (int k = 0; k < K1; k++) begin
        job_w1[r][k] = byte'($urandom_range(0, 255));
        for (int i = 0; i < MN; i++) job_din[r][k][i] = byte'($urandom_range(0, 255));
      end
    end
    job_shift = $urandom_range(0, 12);
  endtask

  function automatic bit stall_of(input int mode);
    return (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
  endfunction

  // Single compare process: matmul_o must hold the last finished result every cycle, and each
  // done pulse must be expected and carry the modelled result and saturation flag.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      exp_vec = '0;
    end else begin
      if (done_o) begin
        check("done_expected", done_expected, 1'b1);
        exp_vec = pend_vec;
        done_count++;
        done_cyc = cyc;
        check("done_sat", sat_o, pend_sat);
      end
      check("matmul_hold", matmul_o, exp_vec);
      check("ready_excl", l1_ready_o & l2_ready_o, 1'b0);
    end
  end

  task automatic wait_ready(input bit layer2, output bit ok);
    int n = 0;
    while (!(layer2 ? l2_ready_o : l1_ready_o) && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    ok = layer2 ? l2_ready_o : l1_ready_o;
    if (!ok) check(layer2 ? "l2_ready_wait" : "l1_ready_wait", ok, 1'b1);
  endtask

  task automatic send_l1(input int r, input int k, input bit stall, output bit ok);
    l1_valid_i = 1'b0;
    wait_ready(1'b0, ok);
    if (!ok) return;
    if (stall) begin
      bubbles++;
      @(negedge clk_i);
    end
    for (int i = 0; i < MN; i++) l1_din_i[i*DW +: DW] = job_din[r][k][i];
    l1_win_i = job_w1[r][k];
    l1_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    l1_valid_i = 1'b0;
  endtask

  task automatic send_l2(input int r, input bit stall, output bit ok);
    l2_valid_i = 1'b0;
    wait_ready(1'b1, ok);
    if (!ok) return;
    if (stall) begin
      bubbles++;
      @(negedge clk_i);
    end
    l2_win_i = job_w2[r];
    l2_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    l2_valid_i = 1'b0;
  endtask

  // Abort arrives together with a valid layer-2 beat; the abort must win.
  task automatic do_abort(input int r);
    bit ok;
    wait_ready(1'b1, ok);
    if (!ok) return;
    l2_win_i = job_w2[r];
    l2_valid_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    abort_i = 1'b0;
    l2_valid_i = 1'b0;
    check("abort_busy", busy_o, 1'b0);
    check("abort_l2_ready", l2_ready_o, 1'b0);
    check("abort_sat", sat_o, pend_sat);
    check("abort_hold", matmul_o, exp_vec);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic do_reset();
    l1_valid_i = 1'b0;
    l2_valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    check("rst_matmul", matmul_o, '0);
    check("rst_done", done_o, 1'b0);
    check("rst_sat", sat_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_l1_ready", l1_ready_o, 1'b0);
    check("rst_l2_ready", l2_ready_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  // bp_mode: 0 no stalls, 1 stall before every beat, 2 random stalls.
  task automatic run_job(input int bp_mode, input int abort_row, input int reset_after);
    int t0, dc0, n, sent;
    bit ok;
    compute_model();
    bubbles = 0;
    dc0 = done_count;
    done_expected = (abort_row < 0) && (reset_after < 0);
    @(negedge clk_i);
    start_i = 1'b1;
    shift_i = 5'(job_shift);
    t0 = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    shift_i = 5'($urandom_range(0, 31));
    sent = 0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < K1; k++) begin
        if (sent == reset_after) begin
          do_reset();
          return;
        end
        // A stray start mid-job must be ignored.
        start_i = (sent == 5);
        send_l1(r, k, stall_of(bp_mode), ok);
        start_i = 1'b0;
        if (!ok) return;
        sent++;
      end
    end
    for (int r = 0; r < DEPTH; r++) begin
      if (r == abort_row) begin
        do_abort(r);
        return;
      end
      send_l2(r, stall_of(bp_mode), ok);
      if (!ok) return;
    end
    n = 0;
    while (done_count == dc0 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("done_pulse", done_count, dc0 + 1);
    check("done_cycle", done_cyc, t0 + BASE_LAT + bubbles);
    done_expected = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    shift_i = '0;
    l1_valid_i = 1'b0;
    l1_din_i = '0;
    l1_win_i = '0;
    l2_valid_i = 1'b0;
    l2_win_i = '0;
    #1;
    check("por_matmul", matmul_o, '0);
    check("por_done", done_o, 1'b0);
    check("por_busy", busy_o, 1'b0);
    check("por_sat", sat_o, 1'b0);
    check("por_ready", {l1_ready_o, l2_ready_o}, '0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    // abort in IDLE has no effect
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("idle_abort_busy", busy_o, 1'b0);

    fill_const(1, 1, 1, 0);
    compute_model();
    check("model_ones", pend_vec, vec_all(64));
    run_job(0, -1, -1);
    check("ones_lanes", matmul_o, vec_all(64));
    check("ones_sat", sat_o, 1'b0);

    fill_const(127, 127, 1, 0);
    compute_model();
    check("model_sat", pend_vec, vec_all(1016));
    run_job(0, -1, -1);
    check("sat_lanes", matmul_o, vec_all(1016));
    check("sat_flag", sat_o, 1'b1);

    fill_const(-3, 5, -1, 2);
    compute_model();
    check("model_signed", pend_vec, vec_all(240));
    run_job(0, -1, -1);
    check("signed_lanes", matmul_o, vec_all(240));
    check("signed_sat", sat_o, 1'b0);

    fill_const(1, 1, 1, 0);
    run_job(1, -1, -1);
    check("bp_lanes", matmul_o, vec_all(64));
    check("bp_bubbles", bubbles, DEPTH * K1 + DEPTH);

    fill_rand();
    run_job(0, 3, -1);
    check("post_abort_lanes", matmul_o, vec_all(64));
    fill_const(1, 1, 1, 0);
    run_job(0, -1, -1);
    check("after_abort_lanes", matmul_o, vec_all(64));

    fill_rand();
    run_job(0, -1, 20);
    check("post_reset_busy", busy_o, 1'b0);
    fill_const(1, 1, 1, 0);
    run_job(0, -1, -1);
    check("after_reset_lanes", matmul_o, vec_all(64));

    for (int j = 0; j < 8; j++) begin
      fill_rand();
      run_job($urandom_range(0, 2), -1, -1);
    end
    fill_rand();
    run_job(2, $urandom_range(0, DEPTH - 1), -1);
    fill_rand();
    run_job(2, -1, -1);

    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matmul_chain_seq.md
MATMUL_CHAIN_SEQ -- requirements
Module: matmul_chain_seq

Interface
REQ-001 Parameters:
- DATA_WIDTH, default 8: signed activation and intermediate lane width.
- WEIGHT_WIDTH, default 8: signed weight width.
- ACC_WIDTH, default 32: accumulator and output lane width.
- MAC_NUM, default 8: parallel lanes.
- K1, default 8: layer-1 beats per intermediate row.
- DEPTH, default 8: intermediate rows, which is also the layer-2 beat count.

REQ-002 Ports:
- clk_i, input, 1: single clock, rising edge.
- rstn_i, input, 1: reset, asynchronous, active-low.
- start_i, input, 1: begin a job; honoured only in IDLE.
- abort_i, input, 1: synchronous abandon of the current job.
- shift_i, input, 5: requantisation right-shift, sampled when start_i is accepted.
- l1_valid_i, input, 1: layer-1 beat valid.
- l1_ready_o, output, 1: layer-1 beat ready.
- l1_din_i, input, MAC_NUM*DATA_WIDTH: activation vector, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- l1_win_i, input, WEIGHT_WIDTH: layer-1 scalar weight.
- l2_valid_i, input, 1: layer-2 beat valid.
- l2_ready_o, output, 1: layer-2 beat ready.
- l2_win_i, input, WEIGHT_WIDTH: layer-2 scalar weight.
- busy_o, output, 1: high whenever state is not IDLE.
- done_o, output, 1: one-cycle completion pulse.
- sat_o, output, 1: sticky flag, set if any requantisation saturated in the current or last job.
- matmul_o, output, MAC_NUM*ACC_WIDTH: result lanes, held until the next done.

Function
REQ-003 FSM states are IDLE, L1_ACC, L1_WB, L2_ACC and DONE.
REQ-004 IDLE with start_i=1:
- go to L1_ACC;
- clear accumulators, row counter, beat counter and sat_o;
- latch shift_i.
REQ-005 start_i SHALL be ignored in every state except IDLE.
REQ-006 l1_ready_o is 1 only in L1_ACC; l2_ready_o is 1 only in L2_ACC. A beat transfers only when valid and ready are both 1. With valid low the state holds and no counter advances.
REQ-007 L1_ACC handshake: acc[i] += sext(l1_din[i]) * sext(l1_win); beat increments. The handshake on beat K1-1 moves the FSM to L1_WB.
REQ-008 L1_WB lasts exactly one cycle:
- write q(acc[i]) into temp[row][i];
- clear accumulators and the beat counter;
- if row==DEPTH-1, reset row to 0 and go to L2_ACC; otherwise increment row and go to L1_ACC.
REQ-009 Requantisation q(x):
- arithmetic right shift of x by the latched shift;
- saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
- any clamped lane sets sat_o.
REQ-010 The temp buffer is an internal DEPTH x MAC_NUM x DATA_WIDTH register array. It is not reset, and it is read combinationally in L2_ACC.
REQ-011 L2_ACC handshake: acc[i] += sext(temp[row][i]) * sext(l2_win); row increments. The handshake on row DEPTH-1 moves the FSM to DONE.
REQ-012 All products and sums are signed two's complement. Accumulators wrap modulo 2^ACC_WIDTH, with no saturation.
REQ-013 On the edge entering DONE, matmul_o is loaded with the accumulators. done_o=1 for exactly the one DONE cycle, and the next state is IDLE.
REQ-014 Latency with no stalls, measured from the start_i cycle t:
- done_o is high at cycle t + DEPTH*(K1+1) + DEPTH + 1, which is 81 for the defaults;
- each stalled beat adds one cycle.
REQ-015 abort_i=1 in any non-IDLE state:
- next state is IDLE;
- no done_o pulse;
- matmul_o and sat_o keep their prior values.
REQ-016 If abort_i and a handshake occur in the same cycle, abort wins and the beat is discarded. abort_i in IDLE has no effect.
REQ-017 The DEPTH==1 and K1==1 boundaries SHALL work, giving single-beat rows and a single-row layer 2.

Reset
REQ-018 With rstn_i low, asynchronously:
- state=IDLE;
- all counters and accumulators are 0;
- outputs: matmul_o=0, done_o=0, sat_o=0, busy_o=0, l1_ready_o=0, l2_ready_o=0.
REQ-019 Reset mid-job discards the job. The first job after deassertion behaves exactly as one started from power-up.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, all at default parameters with valid always high unless stated:
- Ones: din=1, w1=1, shift 0, w2=1 -> every lane 64; done_o at cycle t+81; sat_o=0.
- Saturation: din=127, w1=127, shift 0, w2=1 -> intermediate 129032 clamps to 127; lanes 1016; sat_o=1.
- Signed/shift: din=-3, w1=5 (acc -120), shift 2 -> intermediate -30; w2=-1 -> lanes 240; sat_o=0.
- Backpressure: l1_valid_i and l2_valid_i toggled every other cycle -> same lanes as Ones; done_o delayed by exactly the bubble count.
- Abort: abort_i during L2_ACC -> busy_o falls the next cycle; no done_o; matmul_o retains the previous result; a following start completes correctly.
- Reset mid-L1: rstn_i pulsed low -> all outputs 0 immediately; a new Ones job then gives 64 per lane.
